// File: rtl/tbird_light_sequencer.sv
// Tail-light lamp sequencer: three left and three right lamps, used for
// turn signals and hazard flashing. A clock-enable divider produces a
// one-cycle tick, and the Moore state machine advances only on that tick.
// The switch inputs are asynchronous, so each one passes through a
// two-flop synchroniser before the state machine sees it.
module tbird_light_sequencer #(
  parameter int TICK_COUNT = 12_500_000,
  parameter int CNT_W      = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1
) (
  input  logic       clk,
  input  logic       reset,        // asynchronous, active-low
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  output logic [2:0] lights_left,  // bit0=LA (inner) .. bit2=LC (outer)
  output logic [2:0] lights_right, // bit0=RA (inner) .. bit2=RC (outer)
  output logic       busy,
  output logic       tick
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_L1   = 3'd1,
    S_L2   = 3'd2,
    S_L3   = 3'd3,
    S_R1   = 3'd4,
    S_R2   = 3'd5,
    S_R3   = 3'd6,
    S_HAZ  = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_COUNT - 1);

  // Synchroniser stages, packed as {hazard, right, left}
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;
  logic       sl, sr, sh;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic             haz_req;

  // Synchroniser next values: stage 1 samples the pins, stage 2 samples stage 1
  always_comb begin
    sync1_d = {hazard, right, left};
    sync2_d = sync1_q;
  end

  assign {sh, sr, sl} = sync2_q;

  // Divider: count 0..TICK_COUNT-1 and wrap; tick marks the last count
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  assign tick = (cnt_q == CNT_LAST);

  // Next-state logic; the state only moves on a tick
  always_comb begin
    // NOTE: every signal written in this block gets a value before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    haz_req = sh | (sl & sr);
    if (tick) begin
      if (haz_req) begin
        // Hazard (or both turn switches) toggles between HAZ and IDLE,
        // which gives the one-tick-on / one-tick-off flash.
        state_d = (state_q == S_HAZ) ? S_IDLE : S_HAZ;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (sl)      state_d = S_L1;
            else if (sr) state_d = S_R1;
            else         state_d = S_IDLE;
          end
          // A started sequence always runs to completion
          S_L1:    state_d = S_L2;
          S_L2:    state_d = S_L3;
          S_L3:    state_d = S_IDLE;
          S_R1:    state_d = S_R2;
          S_R2:    state_d = S_R3;
          S_R3:    state_d = S_IDLE;
          S_HAZ:   state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Lamp and busy decode from the state register only, so inputs cannot glitch them
  always_comb begin
    lights_left  = 3'b000;
    lights_right = 3'b000;
    case (state_q)
      S_L1:    lights_left  = 3'b001;
      S_L2:    lights_left  = 3'b011;
      S_L3:    lights_left  = 3'b111;
      S_R1:    lights_right = 3'b001;
      S_R2:    lights_right = 3'b011;
      S_R3:    lights_right = 3'b111;
      S_HAZ: begin
        lights_left  = 3'b111;
        lights_right = 3'b111;
      end
      default: begin
        lights_left  = 3'b000;
        lights_right = 3'b000;
      end
    endcase
    busy = (state_q != S_IDLE);
  end

  // Register bank: synchronisers, divider counter and state, all cleared by reset
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: flops use non-blocking assignment so every register samples the
    // values from before the edge, independent of statement order.
    if (!reset) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      cnt_q   <= '0;
      state_q <= S_IDLE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_tbird_light_sequencer.sv
// Bench for tbird_light_sequencer with TICK_COUNT=4. A behavioural model
// tracks how many lamps are lit on each side plus a hazard flag, and every
// clock the DUT outputs are compared against it.
module tb_tbird_light_sequencer;

  localparam int TC = 4;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       left   = 1'b0;
  logic       right  = 1'b0;
  logic       hazard = 1'b0;
  logic [2:0] lights_left;
  logic [2:0] lights_right;
  logic       busy;
  logic       tick;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_left  = 0;   // lamps lit on the left side (0..3)
  int         m_right = 0;   // lamps lit on the right side (0..3)
  bit         m_haz   = 1'b0; // all six lamps lit
  int         m_edges = 0;   // clock edges since reset release
  logic [2:0] m_pipe[$];     // inputs in flight through the synchroniser

  tbird_light_sequencer #(.TICK_COUNT(TC)) dut (
    .clk          (clk),
    .reset        (reset),
    .left         (left),
    .right        (right),
    .hazard       (hazard),
    .lights_left  (lights_left),
    .lights_right (lights_right),
    .busy         (busy),
    .tick         (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] bar(input int n);
    return 3'((1 << n) - 1);
  endfunction

  task automatic model_reset();
    m_left  = 0;
    m_right = 0;
    m_haz   = 1'b0;
    m_edges = 0;
    m_pipe  = {3'b000, 3'b000};
  endtask

  // One rising edge: inputs become visible two edges after they are sampled,
  // and the lamps move only on every TC-th edge.
  task automatic model_edge(input logic [2:0] pins); // {hazard, right, left}
    logic [2:0] seen;
    bit         stepping;
    bit         req;
    seen = m_pipe.pop_front();
    m_pipe.push_back(pins);
    stepping = (m_edges % TC) == TC - 1;
    m_edges++;
    if (!stepping) return;
    req = seen[2] | (seen[0] & seen[1]);
    if (req) begin
      m_haz   = !m_haz;
      m_left  = 0;
      m_right = 0;
    end else if (m_haz)      m_haz   = 1'b0;
    else if (m_left > 0)     m_left  = (m_left + 1) % 4;
    else if (m_right > 0)    m_right = (m_right + 1) % 4;
    else if (seen[0])        m_left  = 1;
    else if (seen[1])        m_right = 1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_ll"},   8'(lights_left),  8'(m_haz ? 3'b111 : bar(m_left)));
    check({tag, "_lr"},   8'(lights_right), 8'(m_haz ? 3'b111 : bar(m_right)));
    check({tag, "_busy"}, 8'(busy),         8'(m_haz || m_left != 0 || m_right != 0));
    check({tag, "_tick"}, 8'(tick),         8'((m_edges % TC) == TC - 1));
  endtask

  // Called at a falling edge: drive inputs, take the rising edge, check, and
  // return at the next falling edge.
  task automatic cycle(input logic l, input logic r, input logic h, input string tag);
    left   = l;
    right  = r;
    hazard = h;
    @(posedge clk);
    model_edge({h, r, l});
    #1 check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    left   = 1'b0;
    right  = 1'b0;
    hazard = 1'b0;
    reset  = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic l, r, h;

    // Reset state
    #1 reset = 1'b0;
    model_reset();
    #1 check_outputs("reset");
    repeat (2) @(posedge clk);
    release_reset();

    // Divider with idle inputs: tick in cycles 4, 8, 12
    repeat (12) cycle(1'b0, 1'b0, 1'b0, "div");

    // Left held for 20 ticks, then drain to idle
    repeat (20 * TC) cycle(1'b1, 1'b0, 1'b0, "left");
    repeat (8 * TC) cycle(1'b0, 1'b0, 1'b0, "drain");

    // Early release: drop left as soon as L1 is showing
    n = 0;
    while (m_left != 1 && n < 40) begin
      cycle(1'b1, 1'b0, 1'b0, "early_on");
      n++;
    end
    check("early_wait", 8'(m_left == 1), 8'd1);
    repeat (6 * TC) cycle(1'b0, 1'b0, 1'b0, "early_off");

    // Hazard preempting a right sequence at R2
    n = 0;
    while (m_right != 2 && n < 40) begin
      cycle(1'b0, 1'b1, 1'b0, "preempt_r");
      n++;
    end
    check("preempt_wait", 8'(m_right == 2), 8'd1);
    repeat (8 * TC) cycle(1'b0, 1'b0, 1'b1, "preempt_haz");
    repeat (4 * TC) cycle(1'b0, 1'b0, 1'b0, "preempt_off");

    // Both turn switches behave as hazard
    repeat (8 * TC) cycle(1'b1, 1'b1, 1'b0, "both");
    repeat (4 * TC) cycle(1'b0, 1'b0, 1'b0, "both_off");

    // Asynchronous reset in the middle of L3
    n = 0;
    while (m_left != 3 && n < 60) begin
      cycle(1'b1, 1'b0, 1'b0, "async_l");
      n++;
    end
    check("async_wait", 8'(m_left == 3), 8'd1);
    #2 reset = 1'b0;
    model_reset();
    #1 check_outputs("async");
    repeat (3) @(posedge clk);
    #1 check_outputs("async_hold");
    release_reset();
    repeat (3 * TC) cycle(1'b0, 1'b0, 1'b0, "post_reset");

    // Randomised switch activity with occasional changes
    l = 1'b0;
    r = 1'b0;
    h = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        l = 1'($urandom_range(0, 1));
        r = ($urandom_range(0, 2) == 0);
        h = ($urandom_range(0, 5) == 0);
      end
      cycle(l, r, h, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tbird_light_sequencer.md
Name: tbird_light_sequencer

Overview:
- Controller for the tail-light lamp bank. It sequences three left lamps and three right lamps for turn signals and hazard flashing.
- It sits between the synchronised switch inputs and the lamp drivers.
- It contains a clock-enable divider, so the state machine advances once per tick, not once per clk.
- It is the sequencing layer above the lab's single-input left/right recogniser FSM.

Parameters:
- TICK_COUNT, default 12_500_000: clk cycles per sequencer step. Legal range is ≥1. A value of 1 steps every cycle.
- CNT_W, default $clog2(TICK_COUNT) (minimum 1): width of the divider counter.

Ports:
- clk  input  1  system clock; all flops are rising-edge.
- reset  input  1  asynchronous, active-low reset (reset=0 resets the block).
- left  input  1  left-turn switch; asynchronous to clk.
- right  input  1  right-turn switch; asynchronous to clk.
- hazard  input  1  hazard switch; asynchronous to clk.
- lights_left  output  3  left lamps: bit0=LA (innermost), bit1=LB, bit2=LC.
- lights_right  output  3  right lamps: bit0=RA (innermost), bit1=RB, bit2=RC.
- busy  output  1  high whenever state != IDLE.
- tick  output  1  one-cycle step strobe; exported for debug and bench.

Behaviour:
- Reset (reset=0, asynchronous):
  - divider counter=0, state=IDLE, all synchroniser flops=0.
  - lights_left=000, lights_right=000, busy=0, tick=0.
  - Reset asserted mid-sequence takes effect immediately; the lamps go dark without waiting for a clock edge.
- Input synchronisers:
  - left, right and hazard each pass through a 2-flop synchroniser.
  - The FSM uses only the synchronised copies (sl, sr, sh).
  - Input-to-FSM-visible latency is 2 clk.
- Divider:
  - The counter increments every clk. When it equals TICK_COUNT-1 it wraps to 0.
  - tick = (counter == TICK_COUNT-1), combinational from the counter register.
  - The first tick after reset release is high during the TICK_COUNT-th cycle, then every TICK_COUNT cycles after that.
- FSM: Moore machine. The state register updates only on clk edges where tick=1; otherwise it holds.
- States and lamp decode (lights_left / lights_right):
  - IDLE: 000 / 000
  - L1: 001 / 000; L2: 011 / 000; L3: 111 / 000
  - R1: 000 / 001; R2: 000 / 011; R3: 000 / 111
  - HAZ: 111 / 111
- Transitions on tick, highest priority first:
  - Any state, sh=1 or (sl=1 and sr=1): go to HAZ, except HAZ itself, which goes to IDLE. Hazard therefore flashes all six lamps on/off with 1 tick on and 1 tick off.
  - IDLE, sl=1: go to L1.
  - IDLE, sr=1: go to R1.
  - IDLE, neither: stay in IDLE.
  - L1→L2→L3→IDLE, unconditionally. A started sequence completes even if sl drops. If sr rises mid-sequence, it is honoured only after returning to IDLE.
  - R1→R2→R3→IDLE, likewise.
  - HAZ with sh=0 and not both turn inputs: go to IDLE.
- Hazard preemption: hazard asserted during an L or R sequence enters HAZ at the next tick. No partial lamp pattern is retained.
- Both turn inputs held: treated as hazard.
- Turn input held continuously: the sequence repeats as IDLE, L1, L2, L3, IDLE, L1, … A period is 4 ticks and includes one dark tick.
- Outputs:
  - All lamp outputs and busy are decoded from the state register only, so they are glitch-free with respect to the inputs.
  - Outputs change 0 clk after the ticking edge.
- Illegal state encodings decode to dark lamps and go to IDLE at the next tick.

Test Plan (TICK_COUNT=4 in sim):
- Divider: release reset, inputs 0. Expect tick high exactly in cycles 4, 8, 12 after release, lamps 000/000, busy=0 throughout.
- Left turn: hold left=1 for 20 ticks. Expect lights_left to step 001, 011, 111, 000 on consecutive ticks, repeating. lights_right stays 000.
- Early release: left=1 until L1 is entered, then left=0. Expect L2 (011), L3 (111), then IDLE and it stays dark.
- Hazard preempt: right sequence at R2 (011), assert hazard. Expect the next tick gives 111/111, then 000/000, then 111/111, alternating while hazard=1.
- Both turn inputs: left=right=1 from IDLE. Expect the same alternating 111/111 ↔ 000/000 as hazard.
- Async reset: drive reset=0 mid-L3, between clock edges. Expect outputs 000/000 and busy=0 immediately. After release, the first tick arrives TICK_COUNT cycles later.
